// File: rtl/pipelined_shifter.sv
// Pipelined log barrel shifter (SLL/SRL/SRA, op 11 = ROL or pass), valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to build rotate-left for op 11; otherwise op 11 passes data through.
module pipelined_shifter #(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [SHIFT_AMOUNT_WIDTH-1:0] in_amount,
    input  logic [1:0]                    in_op,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_zero
);

    localparam int L   = SHIFT_AMOUNT_WIDTH;
    localparam int OPQ = (L > 1) ? L - 1 : 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [DATA_WIDTH-1:0] data_q    [L];
    logic [DATA_WIDTH-1:0] data_d    [L];
    logic [DATA_WIDTH-1:0] stage_src [L];
    logic [1:0]            stage_op  [L];
    logic [L-1:0]          stage_amt;
    logic [L-1:0]          valid_q;
    logic [1:0]            op_q      [OPQ];
    logic                  advance;

    assign advance   = out_ready | ~valid_q[L-1];
    assign in_ready  = advance;
    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];
    assign out_zero  = valid_q[L-1] & (data_q[L-1] == '0);

    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            op,
        input int                    sh
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        unique case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            OP_SRA:  r = $signed(d) >>> sh;
            default: begin
`ifdef SHIFTER_ROTATE_EN
                r = (d << sh) | (d >> (DATA_WIDTH - sh));
`else
                r = d;
`endif
            end
        endcase
        return r;
    endfunction

    for (genvar k = 0; k < L; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_src[k] = in_data;
            assign stage_op[k]  = in_op;
            assign stage_amt[k] = in_amount[0];
        end else begin : g_tail
            // amount bit k only matters at stage k, so it rides a k-deep delay line
            logic [k-1:0] amt_dly_q;

            assign stage_src[k] = data_q[k-1];
            assign stage_op[k]  = op_q[k-1];
            assign stage_amt[k] = amt_dly_q[k-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    amt_dly_q <= '0;
                end else if (advance) begin
                    amt_dly_q[0] <= in_amount[k];
                    for (int i = 1; i < k; i++) begin
                        amt_dly_q[i] <= amt_dly_q[i-1];
                    end
                end
            end
        end

        assign data_d[k] = stage_amt[k]
                         ? shift_step(stage_src[k], stage_op[k], 2**k)
                         : stage_src[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < L; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < OPQ; k++) begin
                op_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < L; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            for (int k = 0; k < L; k++) begin
                data_q[k] <= data_d[k];
            end
            if (L > 1) begin
                op_q[0] <= in_op;
                for (int k = 1; k < L - 1; k++) begin
                    op_q[k] <= op_q[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at DATA_WIDTH=8 (three stages).
// Directed vectors, stall, async reset and a short randomised stream.
module tb_pipelined_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amount;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         rnd_done = 1'b0;

    always #5 clk = ~clk;

    pipelined_shifter #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ref_fn(input logic [7:0] d,
                                          input logic [2:0] a,
                                          input logic [1:0] o);
        logic [7:0] r;
        case (o)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
            default: begin
`ifdef SHIFTER_ROTATE_EN
                r = (d << a) | (d >> (8 - a));
`else
                r = d;
`endif
            end
        endcase
        return r;
    endfunction

    // returns just after the rising edge on which the beat transferred
    task automatic send(input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] o, input logic [7:0] e);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_op     = o;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready=0 want 1");
                return;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic lat_check(input logic [7:0] d, input logic [2:0] a,
                             input logic [1:0] o, input logic [7:0] e);
        send(d, a, o, e);
        in_valid = 1'b0;
        check("lat_c1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_c2", out_valid, 0);
        @(posedge clk); #1;
        check("lat_c3", out_valid, 1);
        check("lat_data", out_data, e);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                    check("out_zero", out_zero, (e == 8'h00));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] o;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    initial begin : stim
        logic [7:0] rd;
        logic [2:0] ra;
        logic [1:0] ro;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_zero", out_zero, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        lat_check(8'h81, 3'd1, 2'b00, 8'h02);
        drain();

        vecs.push_back('{8'h90, 3'd4, 2'b10, 8'hF9});
        vecs.push_back('{8'h90, 3'd4, 2'b01, 8'h09});
        vecs.push_back('{8'h01, 3'd1, 2'b01, 8'h00});
        vecs.push_back('{8'hA5, 3'd0, 2'b00, 8'hA5});
        vecs.push_back('{8'hA5, 3'd0, 2'b01, 8'hA5});
        vecs.push_back('{8'hA5, 3'd0, 2'b10, 8'hA5});
        vecs.push_back('{8'hA5, 3'd0, 2'b11, 8'hA5});
        vecs.push_back('{8'h01, 3'd7, 2'b00, 8'h80});
        vecs.push_back('{8'h7F, 3'd7, 2'b10, 8'h00});
        vecs.push_back('{8'h80, 3'd7, 2'b10, 8'hFF});
        vecs.push_back('{8'h80, 3'd7, 2'b01, 8'h01});
        vecs.push_back('{8'hC3, 3'd3, 2'b00, 8'h18});
`ifdef SHIFTER_ROTATE_EN
        vecs.push_back('{8'h81, 3'd1, 2'b11, 8'h03});
        vecs.push_back('{8'h96, 3'd4, 2'b11, 8'h69});
        vecs.push_back('{8'h80, 3'd7, 2'b11, 8'h40});
`else
        vecs.push_back('{8'h81, 3'd1, 2'b11, 8'h81});
        vecs.push_back('{8'h96, 3'd4, 2'b11, 8'h96});
        vecs.push_back('{8'h80, 3'd7, 2'b11, 8'h80});
`endif
        foreach (vecs[i]) send(vecs[i].d, vecs[i].a, vecs[i].o, vecs[i].e);
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(8'h01, 3'(i), 2'b00, 8'(1 << i));
                end
                in_valid = 1'b0;
            end
            begin
                logic [7:0] held;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                held = out_data;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_hold", out_data, held);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(8'h33, 3'd2, 2'b00, 8'hCC);
        send(8'h44, 3'd1, 2'b01, 8'h22);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_zero", out_zero, 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        lat_check(8'h0F, 3'd2, 2'b00, 8'h3C);
        drain();

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    rd = 8'($urandom);
                    ra = 3'($urandom_range(0, 7));
                    ro = 2'($urandom_range(0, 3));
                    send(rd, ra, ro, ref_fn(rd, ra, ro));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
